// File: rtl/datapath_seq_if.sv
// datapath_seq_if: operation request channel of datapath_seq.
//   in_valid   : requester has an operation to issue
//   in_ready   : datapath can accept an operation this cycle
//   ALUControl : opcode (ADD, SUB, AND, XOR, OR, SLT, SLL, SRL)
//   addr1/2/3  : source A, source B and destination register indices
// The master modport is the requester; the slave modport is the datapath.
interface datapath_seq_if #(
  parameter int AW = 2
);
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    ALUControl;
  logic [AW-1:0] addr1;
  logic [AW-1:0] addr2;
  logic [AW-1:0] addr3;

  modport master (
    output in_valid, ALUControl, addr1, addr2, addr3,
    input  in_ready
  );

  modport slave (
    input  in_valid, ALUControl, addr1, addr2, addr3,
    output in_ready
  );
endinterface

// File: rtl/datapath_seq.sv
// datapath_seq: multi-cycle register-file ALU datapath.
// An accepted operation walks IDLE -> READ -> EXEC -> DONE: operands are
// read in READ, the ALU result is written back (register, result, flags)
// on the EXEC edge and done pulses for the DONE cycle.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   op (slave)        : operation request channel (valid/ready, opcode, addrs)
//   ld_en/addr/data   : host register load, honoured only in IDLE, wins over op
//   rd_addr/rd_data   : combinational debug read of the register file
//   result, Zero, Ovf : value and flags of the last write-back
//   done              : one-cycle pulse following a write-back
module datapath_seq #(
  parameter  int WIDTH = 32,
  parameter  int NREGS = 4,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  datapath_seq_if.slave        op,
  input  logic                 ld_en,
  input  logic [AW-1:0]        ld_addr,
  input  logic [WIDTH-1:0]     ld_data,
  input  logic [AW-1:0]        rd_addr,
  output logic [WIDTH-1:0]     rd_data,
  output logic [WIDTH-1:0]     result,
  output logic                 Zero,
  output logic                 Ovf,
  output logic                 done
);
  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] regs_r [NREGS];
  logic [2:0]       opc_r;
  logic [AW-1:0]    a1_r;
  logic [AW-1:0]    a2_r;
  logic [AW-1:0]    a3_r;
  logic [WIDTH-1:0] opa_r;
  logic [WIDTH-1:0] opb_r;
  logic [WIDTH:0]   alu_s;
  logic [WIDTH-1:0] result_r;
  logic             zero_r;
  logic             ovf_r;
  logic             done_r;
  logic             accept_s;
  logic             load_s;

  // ALU: returns {signed_overflow, value}; overflow only meaningful for ADD/SUB.
  function automatic logic [WIDTH:0] alu_f(input logic [2:0] opc,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    logic             v;
    r = {WIDTH{1'b0}};
    v = 1'b0;
    case (opc)
      3'b000: begin
        r = a + b;
        // Same-sign operands producing an opposite-sign sum.
        v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      3'b001: begin
        r = a - b;
        // Different-sign operands where the difference takes B's sign.
        v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      3'b010:  r = a & b;
      3'b011:  r = a ^ b;
      3'b100:  r = a | b;
      3'b101:  r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      3'b110:  r = a << b[SW-1:0];
      3'b111:  r = a >> b[SW-1:0];
      default: r = {WIDTH{1'b0}};
    endcase
    return {v, r};
  endfunction

  assign accept_s    = (state_r == IDLE) && op.in_valid && !ld_en;
  assign load_s      = (state_r == IDLE) && ld_en;
  assign op.in_ready = rst && (state_r == IDLE) && !ld_en;
  assign alu_s       = alu_f(opc_r, opa_r, opb_r);
  assign rd_data     = regs_r[rd_addr];
  assign result      = result_r;
  assign Zero        = zero_r;
  assign Ovf         = ovf_r;
  assign done        = done_r;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: only IDLE waits; the other states advance unconditionally.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = READ;
        end else begin
          state_next_s = IDLE;
        end
      end
      READ:    state_next_s = EXEC;
      EXEC:    state_next_s = DONE;
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Register file: reset to R[i]=i, written by EXEC write-back or an IDLE host load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= WIDTH'(i);
      end
    end else if (state_r == EXEC) begin
      regs_r[a3_r] <= alu_s[WIDTH-1:0];
    end else if (load_s) begin
      regs_r[ld_addr] <= ld_data;
    end
  end

  // Operation capture: opcode/addresses on acceptance, operand values in READ.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opc_r <= 3'b000;
      a1_r  <= {AW{1'b0}};
      a2_r  <= {AW{1'b0}};
      a3_r  <= {AW{1'b0}};
      opa_r <= {WIDTH{1'b0}};
      opb_r <= {WIDTH{1'b0}};
    end else begin
      if (accept_s) begin
        opc_r <= op.ALUControl;
        a1_r  <= op.addr1;
        a2_r  <= op.addr2;
        a3_r  <= op.addr3;
      end
      if (state_r == READ) begin
        opa_r <= regs_r[a1_r];
        opb_r <= regs_r[a2_r];
      end
    end
  end

  // Write-back outputs: result/flags held between write-backs, done follows EXEC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_r <= {WIDTH{1'b0}};
      zero_r   <= 1'b0;
      ovf_r    <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      if (state_r == EXEC) begin
        result_r <= alu_s[WIDTH-1:0];
        zero_r   <= (alu_s[WIDTH-1:0] == {WIDTH{1'b0}});
        ovf_r    <= alu_s[WIDTH] && (opc_r == 3'b000 || opc_r == 3'b001);
      end
      done_r <= (state_r == EXEC);
    end
  end
endmodule

// File: tb/tb_datapath_seq.sv
// tb_datapath_seq: self-checking bench for datapath_seq (WIDTH=32, NREGS=4).
// A transaction-level model (register array, expected outputs, ALU computed
// with wide signed arithmetic) is advanced by the stimulus tasks; a compare
// process checks every DUT output against it on each falling edge.
module tb_datapath_seq;
  localparam int WIDTH = 32;
  localparam int NREGS = 4;
  localparam int AW    = 2;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic             clk = 1'b0;
  logic             rst;
  logic             ld_en;
  logic [AW-1:0]    ld_addr;
  logic [WIDTH-1:0] ld_data;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             ovf;
  logic             done;

  datapath_seq_if #(.AW(AW)) bus ();

  datapath_seq #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
    .clk     (clk),
    .rst     (rst),
    .op      (bus),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .result  (result),
    .Zero    (zero),
    .Ovf     (ovf),
    .done    (done)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_count = 0;
  int exp_acc = 0;
  int last_acc = 0;
  int prev_acc = 0;

  // Behavioural model state.
  logic [31:0] m_regs [NREGS];
  logic [31:0] m_result;
  logic        m_zero;
  logic        m_ovf;
  logic        m_done;
  logic        m_idle;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // {ovf, value} from the opcode definitions using 64-bit signed arithmetic.
  function automatic logic [32:0] model_alu(input logic [2:0] opc, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa;
    longint sb;
    longint s;
    logic [31:0] res;
    logic v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s = 0;
    res = 32'd0;
    v = 1'b0;
    case (opc)
      3'd0: begin s = sa + sb; res = 32'(s); v = (s > SMAX) || (s < SMIN); end
      3'd1: begin s = sa - sb; res = 32'(s); v = (s > SMAX) || (s < SMIN); end
      3'd2: res = a & b;
      3'd3: res = a ^ b;
      3'd4: res = a | b;
      3'd5: res = (sa < sb) ? 32'd1 : 32'd0;
      3'd6: res = a << (b % 32);
      3'd7: res = a >> (b % 32);
      default: res = 32'd0;
    endcase
    return {v, res};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = 32'(i);
    m_result = 32'd0;
    m_zero = 1'b0;
    m_ovf = 1'b0;
    m_done = 1'b0;
    m_idle = 1'b1;
  endtask

  // Random traffic on every input the datapath must ignore while busy.
  task automatic noise_drive(input bit noise);
    if (noise) begin
      ld_en = 1'($urandom_range(0, 1));
      ld_addr = 2'($urandom);
      ld_data = $urandom;
      bus.ALUControl = 3'($urandom);
      bus.addr1 = 2'($urandom);
      bus.addr2 = 2'($urandom);
      bus.addr3 = 2'($urandom);
    end
  endtask

  // Issue one operation starting #1 after a rising edge; returns #1 after the
  // edge at which the datapath is idle again (acceptance edge + 3).
  task automatic do_op(input logic [2:0] opc, input logic [1:0] a1, input logic [1:0] a2,
                       input logic [1:0] a3, input bit hold, input bit noise);
    logic [32:0] r;
    bus.in_valid = 1'b1;
    bus.ALUControl = opc;
    bus.addr1 = a1;
    bus.addr2 = a2;
    bus.addr3 = a3;
    @(posedge clk);
    r = model_alu(opc, m_regs[a1], m_regs[a2]);
    exp_acc++;
    #1;
    m_idle = 1'b0;
    bus.in_valid = hold;
    noise_drive(noise);
    @(posedge clk);
    #1;
    noise_drive(noise);
    @(posedge clk);
    #1;
    m_regs[a3] = r[31:0];
    m_result = r[31:0];
    m_ovf = r[32];
    m_zero = (r[31:0] == 32'd0);
    m_done = 1'b1;
    noise_drive(noise);
    @(posedge clk);
    #1;
    m_done = 1'b0;
    m_idle = 1'b1;
    ld_en = 1'b0;
  endtask

  task automatic do_load(input logic [1:0] addr, input logic [31:0] data);
    ld_en = 1'b1;
    ld_addr = addr;
    ld_data = data;
    @(posedge clk);
    #1;
    m_regs[addr] = data;
    ld_en = 1'b0;
  endtask

  // Load and op requested together: load wins, op is accepted one cycle later.
  task automatic do_load_op(input logic [1:0] laddr, input logic [31:0] ldat,
                            input logic [2:0] opc, input logic [1:0] a1,
                            input logic [1:0] a2, input logic [1:0] a3);
    bus.in_valid = 1'b1;
    bus.ALUControl = opc;
    bus.addr1 = a1;
    bus.addr2 = a2;
    bus.addr3 = a3;
    do_load(laddr, ldat);
    do_op(opc, a1, a2, a3, 1'b0, 1'b0);
  endtask

  initial begin : clkgen
    forever #5 clk = ~clk;
  end

  // Debug read address sweeps all registers, one per cycle.
  initial begin : rdsweep
    rd_addr = 2'd0;
    forever begin
      @(posedge clk);
      #1;
      rd_addr = rd_addr + 2'd1;
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  initial begin : compare
    forever begin
      @(negedge clk);
      cyc++;
      chk("in_ready", 32'(bus.in_ready), 32'(rst && m_idle && !ld_en));
      chk("done", 32'(done), 32'(m_done));
      chk("result", result, m_result);
      chk("Zero", 32'(zero), 32'(m_zero));
      chk("Ovf", 32'(ovf), 32'(m_ovf));
      chk("rd_data", rd_data, m_regs[rd_addr]);
      if (rst && bus.in_valid && bus.in_ready) begin
        acc_count++;
        prev_acc = last_acc;
        last_acc = cyc;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin : stim
    rst = 1'b0;
    ld_en = 1'b0;
    ld_addr = 2'd0;
    ld_data = 32'd0;
    bus.in_valid = 1'b0;
    bus.ALUControl = 3'd0;
    bus.addr1 = 2'd0;
    bus.addr2 = 2'd0;
    bus.addr3 = 2'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Dependent chain from reset values 0,1,2,3.
    do_op(3'd0, 2'd1, 2'd2, 2'd0, 1'b0, 1'b0);
    chk("seq_add", result, 32'd3);
    do_op(3'd2, 2'd2, 2'd3, 2'd1, 1'b0, 1'b0);
    chk("seq_and", result, 32'd2);
    do_op(3'd3, 2'd2, 2'd0, 2'd3, 1'b0, 1'b0);
    chk("seq_xor", result, 32'd1);
    do_op(3'd1, 2'd1, 2'd3, 2'd2, 1'b0, 1'b0);
    chk("seq_sub", result, 32'd1);
    chk("seq_zero", 32'(zero), 32'd0);
    chk("seq_model_r0", m_regs[0], 32'd3);
    chk("seq_model_r1", m_regs[1], 32'd2);
    chk("seq_model_r2", m_regs[2], 32'd1);
    chk("seq_model_r3", m_regs[3], 32'd1);

    // Signed overflow on ADD and SUB.
    do_load(2'd0, 32'h7FFF_FFFF);
    do_load(2'd1, 32'd1);
    do_op(3'd0, 2'd0, 2'd1, 2'd2, 1'b0, 1'b0);
    chk("ovf_add_res", result, 32'h8000_0000);
    chk("ovf_add_ovf", 32'(ovf), 32'd1);
    chk("ovf_add_zero", 32'(zero), 32'd0);
    do_op(3'd1, 2'd2, 2'd1, 2'd3, 1'b0, 1'b0);
    chk("ovf_sub_res", result, 32'h7FFF_FFFF);
    chk("ovf_sub_ovf", 32'(ovf), 32'd1);

    // Zero flag, signed compare, shift amount masking.
    do_op(3'd1, 2'd1, 2'd1, 2'd1, 1'b0, 1'b0);
    chk("zero_res", result, 32'd0);
    chk("zero_flag", 32'(zero), 32'd1);
    chk("zero_ovf", 32'(ovf), 32'd0);
    do_load(2'd0, 32'hFFFF_FFFF);
    do_load(2'd2, 32'd1);
    do_op(3'd5, 2'd0, 2'd2, 2'd3, 1'b0, 1'b0);
    chk("slt_res", result, 32'd1);
    do_load(2'd2, 32'h21);
    do_op(3'd7, 2'd0, 2'd2, 2'd3, 1'b0, 1'b0);
    chk("srl_res", result, 32'h7FFF_FFFF);
    chk("srl_model_r3", m_regs[3], 32'h7FFF_FFFF);

    // Load and request together, then back-to-back with in_valid held high.
    do_load_op(2'd1, 32'd5, 3'd0, 2'd1, 2'd1, 2'd0);
    chk("ldop_res", result, 32'd10);
    do_op(3'd0, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0);
    chk("hold_add_res", result, 32'd15);
    do_op(3'd4, 2'd2, 2'd0, 2'd3, 1'b1, 1'b0);
    chk("hold_gap1", 32'(last_acc - prev_acc), 32'd4);
    chk("hold_or_res", result, 32'd15);
    do_op(3'd6, 2'd1, 2'd1, 2'd0, 1'b0, 1'b0);
    chk("hold_gap2", 32'(last_acc - prev_acc), 32'd4);
    chk("hold_sll_res", result, 32'hA0);

    // Reset during EXEC of ADD R0<-R1+R2 aborts the operation.
    bus.in_valid = 1'b1;
    bus.ALUControl = 3'd0;
    bus.addr1 = 2'd1;
    bus.addr2 = 2'd2;
    bus.addr3 = 2'd0;
    @(posedge clk);
    exp_acc++;
    #1;
    m_idle = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_result", result, 32'd0);
    chk("abort_flags", 32'({zero, ovf, done}), 32'd0);
    chk("abort_model_r2", m_regs[2], 32'd2);
    repeat (4) @(posedge clk);
    #1;

    // Randomized traffic; busy periods carry noise on ignored inputs.
    for (int k = 0; k < 150; k++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 2) begin
        do_load(2'($urandom), $urandom);
      end else if (sel == 2) begin
        @(posedge clk);
        #1;
      end else if (sel == 3) begin
        do_load_op(2'($urandom), $urandom, 3'($urandom), 2'($urandom), 2'($urandom),
                   2'($urandom));
      end else begin
        do_op(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 1'b0, 1'b1);
      end
    end
    repeat (4) @(posedge clk);
    #1;
    chk("accept_count", 32'(acc_count), 32'(exp_acc));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
